// File: rtl/bist_pkg.sv
// -----------------------------------------------------------------------------
// bist_pkg
// Shared definitions for the BIST path: the pattern generator, the signature
// analyser and the BIST controller all use the same FSM state encoding and
// default widths.
//   LFSR_N_DEFAULT  default LFSR width
//   CNT_W_DEFAULT   default width of the bit-count register
//   bist_state_t    IDLE -> LOAD -> RUN -> DONE -> IDLE
// -----------------------------------------------------------------------------
package bist_pkg;

    localparam int LFSR_N_DEFAULT = 8;
    localparam int CNT_W_DEFAULT  = 16;

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_LOAD_ENC = 2'd1;
    localparam logic [1:0] ST_RUN_ENC  = 2'd2;
    localparam logic [1:0] ST_DONE_ENC = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_LOAD = ST_LOAD_ENC,
        ST_RUN  = ST_RUN_ENC,
        ST_DONE = ST_DONE_ENC
    } bist_state_t;

endpackage

// File: rtl/lfsr_galois_step.sv
// -----------------------------------------------------------------------------
// lfsr_galois_step
// Combinational single step of a right-shifting Galois LFSR. Bit 0 is the
// output bit; it is fed back into bit N-1 and XORed into every bit whose tap
// is set in poly.
// Ports:
//   state       in  N  current LFSR state
//   poly        in  N  feedback taps (bit N-1 is implicit, always fed back)
//   next_state  out N  state after one shift
// -----------------------------------------------------------------------------
module lfsr_galois_step #(
    parameter int N = 8
) (
    input  logic [N-1:0] state,
    input  logic [N-1:0] poly,
    output logic [N-1:0] next_state
);

    // The top tap carries no information: feedback always enters bit N-1.
    logic unused_poly_msb;
    assign unused_poly_msb = poly[N-1];

    assign next_state[N-1] = state[0];

    generate
        for (genvar gi = 0; gi < N - 1; gi++) begin : g_tap
            assign next_state[gi] = (state[0] & poly[gi]) ^ state[gi+1];
        end
    endgenerate

endmodule

// File: rtl/lfsr_pattern_gen.sv
// -----------------------------------------------------------------------------
// lfsr_pattern_gen
// Serial pseudo-random BIST stimulus generator. A Galois LFSR with run-time
// polynomial and seed emits a bounded serial stream (num_bits bits) under a
// start/done handshake. hold stalls the stream without losing state.
// Optional feature macro: ZERO_SEED_GUARD_EN -- a zero seed is replaced by 1
// at load time and the sticky seed_err output is raised.
// Ports:
//   clk         in   1      clock
//   rst         in   1      asynchronous active-high reset
//   start       in   1      begin a run (sampled in IDLE only)
//   poly        in   N      feedback taps, latched on accepted start
//   seed        in   N      initial LFSR state, latched on accepted start
//   num_bits    in   CNT_W  run length, latched on accepted start
//   hold        in   1      stall the stream while high in RUN
//   sout        out  1      serial stimulus bit (lfsr[0])
//   sout_valid  out  1      sout carries a live bit this cycle
//   pattern     out  N      current LFSR state
//   busy        out  1      high in LOAD and RUN
//   done        out  1      one-cycle end-of-run pulse
//   bits_sent   out  CNT_W  bits emitted in the current/last run
//   seed_err    out  1      (guard build only) zero seed was replaced
// -----------------------------------------------------------------------------
module lfsr_pattern_gen
    import bist_pkg::*;
#(
    parameter int N     = LFSR_N_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     poly,
    input  logic [N-1:0]     seed,
    input  logic [CNT_W-1:0] num_bits,
    input  logic             hold,
    output logic             sout,
    output logic             sout_valid,
    output logic [N-1:0]     pattern,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bits_sent
`ifdef ZERO_SEED_GUARD_EN
    ,
    output logic             seed_err
`endif
);

    bist_state_t      state_reg;
    logic [N-1:0]     lfsr_reg;
    logic [N-1:0]     lfsr_next;
    logic [N-1:0]     poly_reg;
    logic [N-1:0]     seed_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] bits_sent_reg;
    logic             shift_en;
`ifdef ZERO_SEED_GUARD_EN
    logic             seed_err_reg;
`endif

    lfsr_galois_step #(
        .N (N)
    ) u_step (
        .state      (lfsr_reg),
        .poly       (poly_reg),
        .next_state (lfsr_next)
    );

    // A bit is consumed on every RUN cycle that is not stalled.
    assign shift_en = (state_reg == ST_RUN) && !hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            lfsr_reg      <= '0;
            poly_reg      <= '0;
            seed_reg      <= '0;
            cnt_reg       <= '0;
            bits_sent_reg <= '0;
`ifdef ZERO_SEED_GUARD_EN
            seed_err_reg  <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        poly_reg      <= poly;
                        seed_reg      <= seed;
                        cnt_reg       <= num_bits;
                        bits_sent_reg <= '0;
`ifdef ZERO_SEED_GUARD_EN
                        seed_err_reg  <= 1'b0;
`endif
                        state_reg     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
`ifdef ZERO_SEED_GUARD_EN
                    // An all-zero state would lock up; substitute 1 and flag it.
                    if (seed_reg == '0) begin
                        lfsr_reg     <= N'(1);
                        seed_err_reg <= 1'b1;
                    end else begin
                        lfsr_reg     <= seed_reg;
                    end
`else
                    lfsr_reg <= seed_reg;
`endif
                    state_reg <= (cnt_reg == '0) ? ST_DONE : ST_RUN;
                end
                ST_RUN: begin
                    if (shift_en) begin
                        lfsr_reg      <= lfsr_next;
                        bits_sent_reg <= bits_sent_reg + CNT_W'(1);
                        // cnt_reg is non-zero here, so the subtraction cannot wrap.
                        if (bits_sent_reg == cnt_reg - CNT_W'(1)) begin
                            state_reg <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign sout       = lfsr_reg[0];
    assign sout_valid = shift_en;
    assign pattern    = lfsr_reg;
    assign busy       = (state_reg == ST_LOAD) || (state_reg == ST_RUN);
    assign done       = (state_reg == ST_DONE);
    assign bits_sent  = bits_sent_reg;
`ifdef ZERO_SEED_GUARD_EN
    assign seed_err   = seed_err_reg;
`endif

endmodule

// File: tb/tb_lfsr_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_lfsr_pattern_gen
// Self-checking bench for lfsr_pattern_gen (N=8, CNT_W=16). Expected LFSR
// states are pushed to a queue when a run is started and popped by a monitor
// whenever sout_valid is seen. Observed bits also feed a serial signature
// analyser model whose result is compared with a golden signature.
// Honours ZERO_SEED_GUARD_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_lfsr_pattern_gen;

    localparam int N     = 8;
    localparam int CNT_W = 16;
    localparam logic [N-1:0] SIG_POLY = 8'h1D;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [N-1:0]     poly = '0;
    logic [N-1:0]     seed = '0;
    logic [CNT_W-1:0] num_bits = '0;
    logic             hold = 1'b0;
    logic             sout;
    logic             sout_valid;
    logic [N-1:0]     pattern;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] bits_sent;
`ifdef ZERO_SEED_GUARD_EN
    logic             seed_err;
`endif

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int obs_cnt = 0;
    logic [N-1:0] sig_obs = '0;
    logic [N-1:0] exp_q[$];

    always #5 clk = ~clk;

    lfsr_pattern_gen #(
        .N     (N),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .poly       (poly),
        .seed       (seed),
        .num_bits   (num_bits),
        .hold       (hold),
        .sout       (sout),
        .sout_valid (sout_valid),
        .pattern    (pattern),
        .busy       (busy),
        .done       (done),
        .bits_sent  (bits_sent)
`ifdef ZERO_SEED_GUARD_EN
        ,
        .seed_err   (seed_err)
`endif
    );

    // Reference step: shift right, then fold the taps in if the output bit was 1.
    function automatic logic [N-1:0] model_step(input logic [N-1:0] s, input logic [N-1:0] p);
        logic [N-1:0] sh;
        sh = s >> 1;
        if (s[0]) sh = sh ^ {1'b1, p[N-2:0]};
        return sh;
    endfunction

    function automatic logic [N-1:0] sig_step(input logic [N-1:0] sig, input logic b);
        return model_step(sig, SIG_POLY) ^ {b, {(N-1){1'b0}}};
    endfunction

    function automatic logic [N-1:0] load_value(input logic [N-1:0] s);
`ifdef ZERO_SEED_GUARD_EN
        return (s == '0) ? N'(1) : s;
`else
        return s;
`endif
    endfunction

    function automatic logic [N-1:0] golden_sig(input logic [N-1:0] p, input logic [N-1:0] s, input int n);
        logic [N-1:0] st;
        logic [N-1:0] g;
        st = load_value(s);
        g = '0;
        for (int k = 0; k < n; k++) begin
            g = sig_step(g, st[0]);
            st = model_step(st, p);
        end
        return g;
    endfunction

    // Scoreboard monitor: every live bit must match the next expected state.
    always @(negedge clk) begin
        if (!rst && sout_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_bit: got pattern=%h with no bit expected", pattern);
            end else begin
                logic [N-1:0] e;
                e = exp_q.pop_front();
                if (pattern !== e || sout !== e[0]) begin
                    errors++;
                    $display("FAIL stream_bit: got pattern=%h sout=%b expected pattern=%h sout=%b",
                             pattern, sout, e, e[0]);
                end
            end
            sig_obs = sig_step(sig_obs, sout);
            obs_cnt++;
        end
        if (!rst && done) done_cnt++;
    end

    // Drive a one-cycle start and push the expected stream; returns in LOAD.
    task automatic start_run(input logic [N-1:0] p, input logic [N-1:0] s, input int n);
        logic [N-1:0] st;
        st = load_value(s);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(st);
            st = model_step(st, p);
        end
        sig_obs = '0;
        poly = p;
        seed = s;
        num_bits = CNT_W'(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok, output int cyc);
        ok = 1'b0;
        cyc = 0;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({sout, sout_valid, busy, done} !== 4'b0000 || pattern !== '0 || bits_sent !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got sout=%b v=%b busy=%b done=%b pat=%h bits=%0d required all 0",
                     sout, sout_valid, busy, done, pattern, bits_sent);
        end
`ifdef ZERO_SEED_GUARD_EN
        checks++;
        if (seed_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_seed_err: got %b required 0", seed_err);
        end
`endif
        @(negedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        int d0, cyc;
        bit ok;
        d0 = done_cnt;
        start_run(8'h1D, 8'h01, 3);
        checks++;
        if (busy !== 1'b1 || sout_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_load: got busy=%b valid=%b required busy=1 valid=0", busy, sout_valid);
        end
        wait_done(20, ok, cyc);
        checks++;
        if (!ok || cyc != 5) begin
            errors++;
            $display("FAIL basic_latency: got done_ok=%b after %0d cycles required done after 5", ok, cyc);
        end
        checks++;
        if (bits_sent !== 16'd3 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_state: got bits_sent=%0d busy=%b required 3, 0", bits_sent, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || done_cnt - d0 != 1 || bits_sent !== 16'd3) begin
            errors++;
            $display("FAIL basic_done_pulse: got done=%b pulses=%0d bits_sent=%0d required 0,1,3",
                     done, done_cnt - d0, bits_sent);
        end
        checks++;
        if (exp_q.size() != 0 || sig_obs !== golden_sig(8'h1D, 8'h01, 3)) begin
            errors++;
            $display("FAIL basic_signature: got sig=%h left=%0d required sig=%h left=0",
                     sig_obs, exp_q.size(), golden_sig(8'h1D, 8'h01, 3));
        end
    endtask

    task automatic test_zero_len;
        int d0, o0, cyc;
        bit ok;
        d0 = done_cnt;
        o0 = obs_cnt;
        start_run(8'h1D, 8'h55, 0);
        wait_done(10, ok, cyc);
        checks++;
        if (!ok || cyc != 2) begin
            errors++;
            $display("FAIL zero_len_latency: got done_ok=%b after %0d cycles required done after 2", ok, cyc);
        end
        @(posedge clk); #1;
        checks++;
        if (obs_cnt != o0 || done_cnt - d0 != 1 || bits_sent !== '0 || done !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_result: got bits=%0d pulses=%0d bits_sent=%0d done=%b required 0,1,0,0",
                     obs_cnt - o0, done_cnt - d0, bits_sent, done);
        end
    endtask

    task automatic test_hold;
        int v, b, o0;
        bit finished;
        v = 0; b = 0; finished = 1'b0;
        o0 = obs_cnt;
        start_run(8'hB8, 8'h5A, 8);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) begin
                finished = 1'b1;
                break;
            end
            if (sout_valid) v++;
            if (busy) b++;
            if (c == 4 || c == 5) begin
                checks++;
                if (sout_valid !== 1'b0 || bits_sent !== 16'd3) begin
                    errors++;
                    $display("FAIL hold_freeze: got valid=%b bits_sent=%0d required 0, 3", sout_valid, bits_sent);
                end
            end
            @(posedge clk); #1;
            hold = (c == 3 || c == 4);
        end
        hold = 1'b0;
        checks++;
        if (!finished || v != 8 || b != 11 || obs_cnt - o0 != 8) begin
            errors++;
            $display("FAIL hold_run: got done=%b valid=%0d busy=%0d required 1, 8, 11", finished, v, b);
        end
        checks++;
        if (bits_sent !== 16'd8 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL hold_count: got bits_sent=%0d left=%0d required 8, 0", bits_sent, exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_midrun_reset;
        int v, d0, cyc;
        bit ok, hit;
        v = 0; hit = 1'b0;
        start_run(8'h8E, 8'hA5, 10);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (sout_valid) v++;
            if (v == 4) begin
                hit = 1'b1;
                break;
            end
        end
        d0 = done_cnt;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (!hit || {sout, sout_valid, busy, done} !== 4'b0000 || pattern !== '0 || bits_sent !== '0) begin
            errors++;
            $display("FAIL midrun_reset: got reached=%b sout=%b v=%b busy=%b done=%b pat=%h bits=%0d required all 0",
                     hit, sout, sout_valid, busy, done, pattern, bits_sent);
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt != d0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrun_no_done: got pulses=%0d busy=%b required 0, 0", done_cnt - d0, busy);
        end
        @(posedge clk); #1;
        start_run(8'h8E, 8'hA5, 10);
        wait_done(30, ok, cyc);
        checks++;
        if (!ok || cyc != 12 || bits_sent !== 16'd10 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL midrun_replay: got done_ok=%b cycles=%0d bits_sent=%0d left=%0d required 1,12,10,0",
                     ok, cyc, bits_sent, exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_start_ignored;
        int b, d0;
        bit finished;
        b = 0; finished = 1'b0;
        d0 = done_cnt;
        start_run(8'h1D, 8'h3C, 6);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done) begin
                finished = 1'b1;
                break;
            end
            if (busy) b++;
            @(posedge clk); #1;
            start = (c == 1 || c == 3);
            num_bits = 16'd2;
            seed = 8'hFF;
        end
        start = 1'b0;
        checks++;
        if (!finished || b != 7 || bits_sent !== 16'd6) begin
            errors++;
            $display("FAIL start_ignored: got done=%b busy_cycles=%0d bits_sent=%0d required 1, 7, 6",
                     finished, b, bits_sent);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done_cnt - d0 != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL start_ignored_idle: got busy=%b pulses=%0d left=%0d required 0, 1, 0",
                     busy, done_cnt - d0, exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_seed;
        int cyc;
        bit ok;
        start_run(8'h1D, 8'h00, 5);
        @(posedge clk); #1;
`ifdef ZERO_SEED_GUARD_EN
        checks++;
        if (seed_err !== 1'b1 || pattern !== 8'h01) begin
            errors++;
            $display("FAIL zero_seed_guard: got seed_err=%b pattern=%h required 1, 01", seed_err, pattern);
        end
`else
        checks++;
        if (pattern !== 8'h00 || sout !== 1'b0) begin
            errors++;
            $display("FAIL zero_seed_literal: got pattern=%h sout=%b required 00, 0", pattern, sout);
        end
`endif
        wait_done(20, ok, cyc);
        checks++;
        if (!ok || bits_sent !== 16'd5 || sig_obs !== golden_sig(8'h1D, 8'h00, 5)) begin
            errors++;
            $display("FAIL zero_seed_signature: got done_ok=%b bits_sent=%0d sig=%h required 1, 5, %h",
                     ok, bits_sent, sig_obs, golden_sig(8'h1D, 8'h00, 5));
        end
        @(posedge clk); #1;
        start_run(8'h1D, 8'h01, 1);
`ifdef ZERO_SEED_GUARD_EN
        checks++;
        if (seed_err !== 1'b0) begin
            errors++;
            $display("FAIL seed_err_clear: got %b required 0", seed_err);
        end
`endif
        wait_done(20, ok, cyc);
        checks++;
        if (!ok || bits_sent !== 16'd1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL short_run: got done_ok=%b bits_sent=%0d left=%0d required 1, 1, 0",
                     ok, bits_sent, exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_hold();
        test_midrun_reset();
        test_start_ignored();
        test_zero_seed();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
